// File: rtl/fpu_writeback.sv
// rtl/fpu_writeback.sv - FPU result FIFO draining into a 32-bit FP register-file write port
module fpu_writeback #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_result,
  input  logic                     in_double,
  input  logic [ADDR_W-1:0]        in_dest,
  input  logic                     stall_in,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [31:0]              wr_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_t;

  logic [63:0]       mem_result [DEPTH];
  logic              mem_double [DEPTH];
  logic [ADDR_W-1:0] mem_dest   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  phase_t            phase;
  phase_t            phase_next;
  logic              push;
  logic              pop;

  logic [63:0]       head_result;
  logic              head_double;
  logic [ADDR_W-1:0] head_dest;

  // A full FIFO only frees a slot on the edge after a pop, never in the same cycle.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;

  assign head_result = mem_result[rd_ptr];
  assign head_double = mem_double[rd_ptr];
  assign head_dest   = mem_dest[rd_ptr];

  // Entry storage; doubles are stored even-aligned so the pair is always {even, odd}.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_double[wr_ptr] <= in_double;
      mem_dest[wr_ptr]   <= in_double ? {in_dest[ADDR_W-1:1], 1'b0} : in_dest;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Phase register: tracks whether the low word of a double head has been written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PH_LO;
    else        phase <= phase_next;
  end

  // Write port drive, pop decision and next phase from the FIFO head.
  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    pop        = 1'b0;
    phase_next = phase;
    if (count != '0) begin
      wr_en = !stall_in;
      if (phase == PH_HI) begin
        wr_addr = {head_dest[ADDR_W-1:1], 1'b1};
        wr_data = head_result[63:32];
        if (wr_en) begin
          pop        = 1'b1;
          phase_next = PH_LO;
        end
      end else if (head_double) begin
        wr_addr = {head_dest[ADDR_W-1:1], 1'b0};
        wr_data = head_result[31:0];
        if (wr_en) phase_next = PH_HI;
      end else begin
        wr_addr = head_dest;
        wr_data = head_result[31:0];
        pop     = wr_en;
      end
    end
  end

endmodule

// File: tb/tb_fpu_writeback.sv
// tb/tb_fpu_writeback.sv - randomized and directed bench for fpu_writeback against a queue model
module tb_fpu_writeback;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_result;
  logic              in_double;
  logic [ADDR_W-1:0] in_dest;
  logic              stall_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [2:0]        count;

  fpu_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_double (in_double),
    .in_dest   (in_dest),
    .stall_in  (stall_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]       res;
    logic              dbl;
    logic [ADDR_W-1:0] dest;
  } ent_t;

  ent_t q[$];
  bit   half_done;
  bit   accepted;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_writes = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs with the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int                n;
    logic              e_ready;
    logic              e_en;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_data;
    @(negedge clk);
    n       = q.size();
    e_ready = (n < DEPTH);
    e_en    = (n != 0) && !stall_in && rst_n;
    e_addr  = '0;
    e_data  = '0;
    if (n != 0) begin
      if (!q[0].dbl) begin
        e_addr = q[0].dest;
        e_data = q[0].res[31:0];
      end else if (!half_done) begin
        e_addr = {q[0].dest[ADDR_W-1:1], 1'b0};
        e_data = q[0].res[31:0];
      end else begin
        e_addr = {q[0].dest[ADDR_W-1:1], 1'b1};
        e_data = q[0].res[63:32];
      end
    end
    check("count",    64'(count),    64'(n));
    check("in_ready", 64'(in_ready), 64'(e_ready));
    check("wr_en",    64'(wr_en),    64'(e_en));
    check("wr_addr",  64'(wr_addr),  64'(e_addr));
    check("wr_data",  64'(wr_data),  64'(e_data));
    if (wr_en) n_writes++;
    @(posedge clk);
    accepted = in_valid && e_ready && rst_n;
    if (e_en) begin
      if (q[0].dbl && !half_done) half_done = 1'b1;
      else begin
        void'(q.pop_front());
        half_done = 1'b0;
      end
    end
    if (accepted) q.push_back('{in_result, in_double, in_dest});
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
    check("drain_done", 64'(q.size()), 64'd0);
  endtask

  task automatic offer(input logic [63:0] r, input logic d, input logic [ADDR_W-1:0] a);
    in_valid  = 1'b1;
    in_result = r;
    in_double = d;
    in_dest   = a;
  endtask

  initial begin
    int w0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_double = 1'b0;
    in_dest   = '0;
    stall_in  = 1'b0;
    half_done = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Single write
    w0 = n_writes;
    offer(64'h0000_0000_3F80_0000, 1'b0, 5'd3);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    check("single_writes", 64'(n_writes - w0), 64'd1);

    // Double pair
    w0 = n_writes;
    offer(64'h4009_21FB_5444_2D18, 1'b1, 5'd7);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    cycle();
    check("double_writes", 64'(n_writes - w0), 64'd2);

    // Fill and backpressure
    stall_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      offer({32'h0, 32'h1000_0000 + 32'(i)}, 1'b0, ADDR_W'(i));
      cycle();
      if (i == 5) check("fifth_refused", 64'(accepted), 64'd0);
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_ready", 64'(in_ready), 64'd0);
    stall_in = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) cycle();
    check("fifth_accepted", 64'(accepted), 64'd1);
    in_valid = 1'b0;
    drain();

    // Stall in the HI half of a double
    w0 = n_writes;
    offer(64'hCAFE_F00D_1234_5678, 1'b1, 5'd10);
    cycle();
    in_valid = 1'b0;
    cycle();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    stall_in = 1'b0;
    drain();
    check("stall_double_writes", 64'(n_writes - w0), 64'd2);

    // Streaming with simultaneous push and pop at count 2
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      offer({32'h0, $urandom}, 1'b0, ADDR_W'($urandom_range(0, 31)));
      cycle();
    end
    stall_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      offer({$urandom, $urandom}, 1'b0, ADDR_W'($urandom_range(0, 31)));
      cycle();
      check("stream_count", 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    drain();

    // Reset while in the HI half
    offer(64'h1111_2222_3333_4444, 1'b1, 5'd12);
    cycle();
    in_valid = 1'b0;
    cycle();
    rst_n     = 1'b0;
    q.delete();
    half_done = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("post_reset_count", 64'(count), 64'd0);
    check("post_reset_wr_en", 64'(wr_en), 64'd0);
    w0 = n_writes;
    offer(64'hDEAD_BEEF_0BAD_F00D, 1'b0, 5'd0);
    cycle();
    in_valid = 1'b0;
    drain();
    check("post_reset_writes", 64'(n_writes - w0), 64'd1);

    // Randomized traffic; the producer holds a refused result
    accepted = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || accepted) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_result = {$urandom, $urandom};
        in_double = $urandom_range(0, 1) == 1;
        in_dest   = ADDR_W'($urandom_range(0, 31));
      end
      stall_in = ($urandom_range(0, 3) == 0);
      cycle();
    end
    in_valid = 1'b0;
    stall_in = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
